// File: rtl/vend_pkg.sv
// vend_pkg: shared states, coin values and default price for the soda vending sequencer
package vend_pkg;
    typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;
    localparam logic [4:0] NICKEL_C = 5'd5;
    localparam logic [4:0] DIME_C = 5'd10;
    localparam logic [4:0] QUARTER_C = 5'd25;
    localparam int PRICE_DEF = 20;
endpackage

// File: rtl/vend_sequencer_coin_edge_detect.sv
// coin_edge_detect: rising-edge detection of the coin buttons with single-press qualification
import vend_pkg::*;
module coin_edge_detect (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       nickel_i,
    input  logic       dime_i,
    input  logic       quarter_i,
    output logic       coin_valid,
    output logic [4:0] coin_value,
    output logic       multi_press
);
    logic [2:0] prev;
    logic [2:0] edges;
    // previous-cycle sample of each button level
    always_ff @(posedge clk_i or negedge reset_ni)
        if (!reset_ni) prev <= '0;
        else prev <= {quarter_i, dime_i, nickel_i};
    assign edges = {quarter_i, dime_i, nickel_i} & ~prev;
    assign coin_valid = $onehot(edges);
    assign multi_press = (edges != '0) && !$onehot(edges);
    assign coin_value = edges[0] ? NICKEL_C : edges[1] ? DIME_C : edges[2] ? QUARTER_C : 5'd0;
endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: coin credit accumulation, soda vend handshake and nickel-by-nickel change return
import vend_pkg::*;
module vend_sequencer #(
    parameter int PRICE = PRICE_DEF,
    parameter int CREDIT_W = 6
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                nickel_i,
    input  logic                dime_i,
    input  logic                quarter_i,
    input  logic                cancel_i,
    output logic                soda_valid_o,
    input  logic                soda_ready_i,
    output logic                change_valid_o,
    input  logic                change_ready_i,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                busy_o,
    output logic                coin_reject_o
);
    localparam logic [CREDIT_W-1:0] PRICE_W = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0] PRICE_X = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] NICKEL_W = CREDIT_W'(NICKEL_C);
    state_t state, state_next;
    logic [CREDIT_W-1:0] credit, credit_next;
    logic [CREDIT_W:0] sum;
    logic coin_valid, multi_press, cancel_prev, cancel_edge, reject_next;
    logic [4:0] coin_value;
    coin_edge_detect u_edge (
        .clk_i(clk_i),
        .reset_ni(reset_ni),
        .nickel_i(nickel_i),
        .dime_i(dime_i),
        .quarter_i(quarter_i),
        .coin_valid(coin_valid),
        .coin_value(coin_value),
        .multi_press(multi_press)
    );
    assign cancel_edge = cancel_i & ~cancel_prev;
    assign sum = {1'b0, credit} + (CREDIT_W+1)'(coin_value);
    // next state, credit update and coin rejection decision
    always_comb begin
        state_next = state;
        credit_next = credit;
        reject_next = multi_press | (coin_valid & (state != COLLECT));
        unique case (state)
            COLLECT:
                if (coin_valid) begin
                    credit_next = sum[CREDIT_W-1:0];
                    state_next = (sum >= PRICE_X) ? VEND : COLLECT;
                end else if (cancel_edge && !multi_press && credit != '0)
                    state_next = CHANGE;
            VEND:
                if (soda_ready_i) begin
                    credit_next = credit - PRICE_W;
                    state_next = (credit_next != '0) ? CHANGE : COLLECT;
                end
            CHANGE:
                if (change_ready_i) begin
                    credit_next = credit - NICKEL_W;
                    state_next = (credit == NICKEL_W) ? COLLECT : CHANGE;
                end
            default: state_next = COLLECT;
        endcase
    end
    // state, credit and registered status outputs
    always_ff @(posedge clk_i or negedge reset_ni)
        if (!reset_ni) begin
            state <= COLLECT;
            credit <= '0;
            cancel_prev <= 1'b0;
            busy_o <= 1'b0;
            coin_reject_o <= 1'b0;
        end else begin
            state <= state_next;
            credit <= credit_next;
            cancel_prev <= cancel_i;
            busy_o <= state_next != COLLECT;
            coin_reject_o <= reject_next;
        end
    assign soda_valid_o = state == VEND;
    assign change_valid_o = state == CHANGE;
    assign credit_o = credit;
endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: table-driven directed check of the vending sequencer
module tb_vend_sequencer;
    typedef struct packed {
        logic [5:0] ins;
        logic [3:0] outs;
        logic [5:0] cred;
    } vec_t;
    logic clk_i = 1'b0;
    logic reset_ni = 1'b0;
    logic nickel_i = 1'b0, dime_i = 1'b0, quarter_i = 1'b0, cancel_i = 1'b0;
    logic soda_ready_i = 1'b0, change_ready_i = 1'b0;
    logic soda_valid_o, change_valid_o, busy_o, coin_reject_o;
    logic [5:0] credit_o;
    int n_checks = 0;
    int n_fail = 0;
    vec_t tv[$];
    vend_sequencer dut (
        .clk_i(clk_i),
        .reset_ni(reset_ni),
        .nickel_i(nickel_i),
        .dime_i(dime_i),
        .quarter_i(quarter_i),
        .cancel_i(cancel_i),
        .soda_valid_o(soda_valid_o),
        .soda_ready_i(soda_ready_i),
        .change_valid_o(change_valid_o),
        .change_ready_i(change_ready_i),
        .credit_o(credit_o),
        .busy_o(busy_o),
        .coin_reject_o(coin_reject_o)
    );
    always #5 clk_i = ~clk_i;
    // ins = {nickel, dime, quarter, cancel, soda_ready, change_ready}; outs = {soda_valid, change_valid, busy, reject}
    task automatic row(input logic [5:0] ins, input logic [3:0] outs, input logic [5:0] cred);
        vec_t v;
        v.ins = ins;
        v.outs = outs;
        v.cred = cred;
        tv.push_back(v);
    endtask
    task automatic drive(input logic [5:0] ins);
        {nickel_i, dime_i, quarter_i, cancel_i, soda_ready_i, change_ready_i} = ins;
    endtask
    task automatic chk(input string name, input logic [3:0] eo, input logic [5:0] ec);
        logic [3:0] ao;
        ao = {soda_valid_o, change_valid_o, busy_o, coin_reject_o};
        n_checks++;
        if (ao !== eo || credit_o !== ec) begin
            n_fail++;
            $display("FAIL %s: got sv/cv/busy/rej=%b credit=%0d, expected %b credit=%0d", name, ao, credit_o, eo, ec);
        end
    endtask
    task automatic step(input logic [5:0] ins, input string name, input logic [3:0] eo, input logic [5:0] ec);
        drive(ins);
        @(posedge clk_i);
        #1;
        chk(name, eo, ec);
    endtask
    initial begin
        row(6'b010011, 4'b0000, 6'd10);
        row(6'b000011, 4'b0000, 6'd10);
        row(6'b010011, 4'b1010, 6'd20);
        row(6'b000011, 4'b0000, 6'd0);
        row(6'b000011, 4'b0000, 6'd0);
        row(6'b001001, 4'b1010, 6'd25);
        row(6'b000001, 4'b1010, 6'd25);
        row(6'b000001, 4'b1010, 6'd25);
        row(6'b000001, 4'b1010, 6'd25);
        row(6'b000001, 4'b1010, 6'd25);
        row(6'b000011, 4'b0110, 6'd5);
        row(6'b000001, 4'b0000, 6'd0);
        row(6'b010000, 4'b0000, 6'd10);
        row(6'b001000, 4'b1010, 6'd35);
        row(6'b000010, 4'b0110, 6'd15);
        row(6'b000001, 4'b0110, 6'd10);
        row(6'b000000, 4'b0110, 6'd10);
        row(6'b000001, 4'b0110, 6'd5);
        row(6'b000000, 4'b0110, 6'd5);
        row(6'b000001, 4'b0000, 6'd0);
        row(6'b000000, 4'b0000, 6'd0);
        row(6'b110000, 4'b0001, 6'd0);
        row(6'b000000, 4'b0000, 6'd0);
        row(6'b010000, 4'b0000, 6'd10);
        row(6'b000000, 4'b0000, 6'd10);
        row(6'b010000, 4'b1010, 6'd20);
        row(6'b001000, 4'b1011, 6'd20);
        row(6'b000000, 4'b1010, 6'd20);
        row(6'b000010, 4'b0000, 6'd0);
        row(6'b100000, 4'b0000, 6'd5);
        row(6'b000000, 4'b0000, 6'd5);
        row(6'b100000, 4'b0000, 6'd10);
        row(6'b000100, 4'b0110, 6'd10);
        row(6'b000001, 4'b0110, 6'd5);
        row(6'b000001, 4'b0000, 6'd0);
        row(6'b000100, 4'b0000, 6'd0);
        row(6'b000000, 4'b0000, 6'd0);
        row(6'b100100, 4'b0000, 6'd5);
        row(6'b000000, 4'b0000, 6'd5);
        row(6'b000101, 4'b0110, 6'd5);
        row(6'b000001, 4'b0000, 6'd0);
        #1;
        chk("reset_state", 4'b0000, 6'd0);
        repeat (2) @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        foreach (tv[i]) step(tv[i].ins, $sformatf("row%0d", i), tv[i].outs, tv[i].cred);
        step(6'b001000, "hold_q_first", 4'b1010, 6'd25);
        for (int k = 0; k < 9; k++) step(6'b001000, $sformatf("hold_q_%0d", k), 4'b1010, 6'd25);
        step(6'b000010, "hold_q_vend", 4'b0110, 6'd5);
        step(6'b000001, "hold_q_change", 4'b0000, 6'd0);
        step(6'b010000, "rst_dime", 4'b0000, 6'd10);
        step(6'b001000, "rst_quarter", 4'b1010, 6'd35);
        step(6'b000010, "rst_in_change", 4'b0110, 6'd15);
        drive(6'b000000);
        #2;
        reset_ni = 1'b0;
        #1;
        chk("async_reset", 4'b0000, 6'd0);
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        step(6'b010000, "post_reset_dime", 4'b0000, 6'd10);
        step(6'b000000, "post_reset_idle", 4'b0000, 6'd10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
- Sequential controller for the coin-operated soda datapath.
- Detects coin presses, accumulates credit, and issues one soda-dispense handshake once credit reaches PRICE.
- Returns change one nickel at a time through a valid/ready handshake to the coin hopper; supports a refund (cancel) request.
- Replaces the free-running accumulate/compare loop with an explicit FSM so vend and change are never lost or duplicated.

Parameters:
- PRICE, 20, vend price in cents; must be a multiple of 5 and at most 40.
- CREDIT_W, 6, credit register width in cents; must hold PRICE+20.

Ports:
- clk_i  input  1  system clock
- reset_ni  input  1  asynchronous active-low reset
- nickel_i  input  1  nickel button level (5 c)
- dime_i  input  1  dime button level (10 c)
- quarter_i  input  1  quarter button level (25 c)
- cancel_i  input  1  refund request level
- soda_valid_o  output  1  soda dispense request
- soda_ready_i  input  1  dispenser accepts soda
- change_valid_o  output  1  request to eject one nickel
- change_ready_i  input  1  hopper accepts one nickel
- credit_o  output  CREDIT_W  current credit in cents
- busy_o  output  1  high in VEND or CHANGE
- coin_reject_o  output  1  one-cycle pulse when a coin press is refused

Behaviour:
- Reset (async, reset_ni=0): state=COLLECT, credit=0, edge registers=0, all outputs 0. Reset takes effect immediately mid-handshake; a pending soda or change is dropped.
- Coin detect: rising edge of each coin input, using the previous-cycle sample. Exactly one edge in a cycle means accept. Two or more edges in the same cycle means reject all of them.
- State COLLECT:
  - Accepted coin: credit <= credit+value at the same clock edge, so credit_o reflects it 1 cycle after the edge.
  - Next state is VEND if credit+value >= PRICE, else COLLECT.
  - cancel_i rising edge with credit>0 and no coin edge: go to CHANGE (full refund).
  - Coin edge and cancel edge in the same cycle: the coin wins, and cancel is ignored.
- State VEND:
  - soda_valid_o=1, held until handshake. Valid must not drop or change while ready=0.
  - On soda_valid_o & soda_ready_i: credit <= credit-PRICE. Next state is CHANGE if the result is nonzero, else COLLECT.
- State CHANGE:
  - change_valid_o=1. Each cycle with change_valid_o & change_ready_i subtracts 5.
  - When the subtraction yields 0, return to COLLECT and drop change_valid_o that same edge.
  - Back-to-back ready gives one nickel per cycle.
- Coin edges or cancel in VEND/CHANGE:
  - Coins produce a coin_reject_o pulse in the next cycle, and credit is unchanged.
  - Cancel is ignored.
- coin_reject_o is registered, 1 cycle after the offending edge, width exactly 1 cycle.
- busy_o is a registered decode of the state.
- Arithmetic is unsigned CREDIT_W-bit. Credit never exceeds PRICE+20 because accumulation stops at PRICE. No wrap is reachable; the subtract in CHANGE is never applied at 0.
- Holding a button produces a single credit; the level must fall and rise again.

Decomposition:
- Package vend_pkg holds:
  - state_t enum {COLLECT, VEND, CHANGE}
  - coin values NICKEL_C=5, DIME_C=10, QUARTER_C=25
  - default PRICE
- One sub-module, coin_edge_detect: registered edge detection plus one-hot check. It outputs coin_valid, coin_value[4:0] and multi_press.
- The FSM and credit datapath stay in vend_sequencer.

Test Plan:
- Single dime then dime, with soda_ready_i tied 1 -> credit_o 10 then 20; soda_valid_o for 1 cycle; credit_o returns to 0; change_valid_o never asserted.
- Quarter press with soda_ready_i held 0 for 5 cycles, change_ready_i=1 -> soda_valid_o stable 5 cycles; after vend handshake, change_valid_o for exactly 1 nickel; credit 25 -> 5 -> 0.
- Dime + quarter (credit 35), change_ready_i toggling 1/0 -> exactly 3 change handshakes; credit 15 -> 10 -> 5 -> 0; then COLLECT with busy_o=0.
- Nickel + dime pressed in the same cycle -> coin_reject_o pulse, credit_o stays 0. Quarter press during VEND -> coin_reject_o, credit unchanged.
- Nickel, nickel, then cancel_i -> 2 change handshakes, credit 10 -> 0, no soda_valid_o. Quarter held high 10 cycles counts once.
- Assert reset_ni low while in CHANGE with credit 15 -> outputs 0 immediately (async); after release, a dime gives credit_o=10.
